uart_ascii_rx: RTL
==================

// Module: uart_ascii_rx
// PURPOSE
//  - UART 8N1 receiver. Sits directly upstream of the character display and
//    drives its ascii/ascii_val input with one received byte per pulse.
//  - Converts the asynchronous serial line into byte strobes on the 25 MHz
//    display clock domain.
//  - Reports framing errors. Optionally checks even parity.
// PARAMETERS
//  - p_clk_freq  25_000_000  clock frequency in Hz
//  - p_baud      115_200     line rate in bit/s
//  - Derived: BIT = p_clk_freq / p_baud (integer division), HALF = BIT / 2.
//    BIT must be >= 4, checked by an elaboration-time assertion.
// PORTS
//  - clk        in   1  single clock; every flop is on its rising edge
//  - rst        in   1  synchronous, active-low reset
//  - rx         in   1  asynchronous serial line, idle high
//  - ascii      out  8  last received byte, LSB first on the wire
//  - ascii_val  out  1  one-cycle strobe: ascii holds a new byte
//  - busy       out  1  high from start-bit detect until return to IDLE
//  - frame_err  out  1  one-cycle strobe: stop bit sampled low
//  - parity_err out  1  one-cycle strobe: parity mismatch (0 without macro)
// BEHAVIOUR
//  - Synchronizer: rx passes through two flops to give rx_s; only rx_s is
//    used. Both flops reset to 1.
//  - Reset (rst==0 at a clock edge), from any state including mid-frame:
//    state=IDLE, ascii=8'h00, ascii_val=0, busy=0, frame_err=0,
//    parity_err=0, armed=0, counters=0, shift register=0.
//  - Counter: cnt counts clocks within a bit; bit_idx counts 0..7.
//  - IDLE:
//    - If rx_s==1, set armed=1.
//    - If armed and rx_s==0, go to START with cnt=0 and busy=1.
//    - A line held low from reset or after a framing error never starts a
//      frame until it has gone high once.
//  - START: when cnt==HALF-1, sample rx_s.
//    - If 1: glitch. Return to IDLE silently with busy=0.
//    - If 0: go to DATA with cnt=0 and bit_idx=0.
//  - DATA: when cnt==BIT-1, shift rx_s into the MSB of the shift register
//    (LSB-first reconstruction) and reset cnt. After bit_idx==7 go to
//    PARITY if the macro is defined, otherwise go to STOP.
//  - PARITY (macro only): sample at cnt==BIT-1 and store the parity bit;
//    go to STOP.
//  - STOP: sample at cnt==BIT-1, then go to IDLE with busy=0.
//    - If rx_s==1 (and parity OK when enabled): ascii<=byte and ascii_val=1
//      on the next cycle only.
//    - If rx_s==0: frame_err=1 for one cycle, ascii unchanged, armed=0.
//    - Parity error takes precedence over delivery: parity_err=1, ascii
//      unchanged. If the stop bit is also low, both strobes assert.
//  - Latency: ascii_val rises exactly 1 clock after the stop-bit sample
//    edge, i.e. about 2 + HALF + 9*BIT clocks after the rx falling edge
//    (plus BIT with parity).
//  - Back-to-back frames: a start bit that begins immediately after the
//    stop sample is accepted. No overrun is possible because the consumer
//    accepts every strobe.
//  - ascii is stable between strobes. ascii_val and the error strobes are
//    never high on consecutive cycles.
// CONFIGURATION
//  - UART_RX_PARITY_EN defined: frame is 8E1. An even-parity bit follows
//    D7. A mismatch (XOR of D0..D7 and P equal to 1) drops the byte and
//    pulses parity_err.
//  - UART_RX_PARITY_EN undefined: frame is 8N1. The PARITY state is absent
//    and parity_err is tied to 0.
// TESTING (p_clk_freq=1600, p_baud=100 => BIT=16, HALF=8)
//  - Reset: hold rst=0 for 3 cycles with rx=1 -> all outputs 0,
//    ascii=8'h00.
//  - Single byte: send 0x41 ('A') 8N1 -> exactly one ascii_val pulse,
//    ascii=8'h41, busy high for about 152 cycles, no error strobes.
//  - Back-to-back: send "Hi" with no idle gap -> two pulses, 8'h48 then
//    8'h69, spaced 160 cycles apart.
//  - Glitch: pulse rx low for 4 cycles -> busy pulses, then returns to
//    IDLE with no ascii_val and no frame_err.
//  - Framing: send 0x55 with stop=0, held low 40 cycles, then a valid 0x31
//    -> one frame_err, no start while low, then ascii=8'h31 with ascii_val.
//  - Mid-frame reset at D3 of 0x7E, then a clean 0x7E -> no strobe for the
//    first frame, one pulse with 8'h7E for the second. With the macro
//    enabled, sending 0x41 with P=1 -> parity_err=1 and ascii unchanged.

Source files
------------

// File: rtl/uart_ascii_rx.sv
// uart_ascii_rx: UART 8N1 receiver delivering one byte strobe per frame to the display.
// Define UART_RX_PARITY_EN for an 8E1 frame with even-parity checking.
module uart_ascii_rx #(
   parameter int p_clk_freq = 25_000_000,
   parameter int p_baud = 115_200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] ascii,
   output logic       ascii_val,
   output logic       busy,
   output logic       frame_err,
   output logic       parity_err
);
   localparam int BIT = p_clk_freq / p_baud;
   localparam int HALF = BIT / 2;
   localparam int CW = $clog2(BIT);
   localparam logic [CW-1:0] BIT_M1 = CW'(BIT - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
   generate
      if (BIT < 4) begin : g_bit_chk
         $error("uart_ascii_rx: p_clk_freq / p_baud must be at least 4");
      end
   endgenerate
   typedef enum logic [2:0] {
      IDLE, START, DATA, STOP
`ifdef UART_RX_PARITY_EN
      , PARITY
`endif
   } state_t;
`ifdef UART_RX_PARITY_EN
   localparam state_t AFTER_DATA = PARITY;
`else
   localparam state_t AFTER_DATA = STOP;
`endif
   state_t state, nstate;
   logic rx_m, rx_s, armed, sample, half, stop_done, par_bad, deliver;
   logic [CW-1:0] cnt;
   logic [2:0] bit_idx;
   logic [7:0] shreg;
`ifdef UART_RX_PARITY_EN
   logic par;
`endif
   always_ff @(posedge clk)
      if (!rst) state <= IDLE;
      else state <= nstate;
   always_comb
      nstate = state == IDLE  ? (armed && !rx_s ? START : IDLE)
             : state == START ? (!half ? START : rx_s ? IDLE : DATA)
             : state == DATA  ? (sample && bit_idx == 3'd7 ? AFTER_DATA : DATA)
`ifdef UART_RX_PARITY_EN
             : state == PARITY ? (sample ? STOP : PARITY)
`endif
             : sample ? IDLE : STOP;
   always_comb begin
      sample = cnt == BIT_M1;
      half = cnt == HALF_M1;
      stop_done = state == STOP && sample;
`ifdef UART_RX_PARITY_EN
      par_bad = ^{shreg, par};
`else
      par_bad = 1'b0;
`endif
      deliver = stop_done && rx_s && !par_bad;
      busy = state != IDLE;
   end
   always_ff @(posedge clk)
      if (!rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         armed <= 1'b0;
         cnt <= '0;
         bit_idx <= 3'd0;
         shreg <= 8'h00;
         ascii <= 8'h00;
         ascii_val <= 1'b0;
         frame_err <= 1'b0;
         parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par <= 1'b0;
`endif
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
         // a low stop bit disarms until the line has been seen idle again
         armed <= stop_done && !rx_s ? 1'b0 : state == IDLE && rx_s ? 1'b1 : armed;
         cnt <= state == IDLE || state != nstate || (state == DATA && sample) ? '0 : cnt + 1'b1;
         bit_idx <= state == DATA ? bit_idx + {2'b00, sample} : 3'd0;
         if (state == DATA && sample) shreg <= {rx_s, shreg[7:1]};
`ifdef UART_RX_PARITY_EN
         if (state == PARITY && sample) par <= rx_s;
`endif
         ascii_val <= deliver;
         frame_err <= stop_done && !rx_s;
         parity_err <= stop_done && par_bad;
         if (deliver) ascii <= shreg;
      end
endmodule
